// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm
//   16-state TAP controller for the s9234 JTAG wrapper. State advances on
//   rising TCLK from TMS. The decoded controls are re-registered on falling
//   TCLK, so they are stable across the next rising edge seen by the
//   scan registers.
//
// Ports
//   TCLK      test clock
//   TRST      async active-high reset, forces Test-Logic-Reset
//   TMS       test mode select
//   clockdr   DR capture/shift clock (gated) or enable (GATE_CLOCKS=0)
//   shiftdr   Shift-DR flag
//   updatedr  DR update strobe, low half-cycle of Update-DR
//   clockir   IR capture/shift clock (gated) or enable (GATE_CLOCKS=0)
//   shiftir   Shift-IR flag
//   updateir  IR update strobe, low half-cycle of Update-IR
//   select    1 = IR column, steers the TDO mux
//   bs_en     TDO output enable
//   tlr       in Test-Logic-Reset, IR loads its default instruction
//   state     current state encoding
//
// state  | meaning
// TLR  F | test-logic-reset
// RTI  C | run-test/idle
// SEL_DR 7 / SEL_IR 4 | select-DR/IR-scan
// CAP_DR 6 / CAP_IR E | capture
// SH_DR  2 / SH_IR  A | shift
// EX1_DR 1 / EX1_IR 9 | exit1
// PAU_DR 3 / PAU_IR B | pause
// EX2_DR 0 / EX2_IR 8 | exit2
// UPD_DR 5 / UPD_IR D | update

module jtag_tap_fsm #(
  parameter bit GATE_CLOCKS = 1'b1
) (
  input  logic       TCLK,
  input  logic       TRST,
  input  logic       TMS,
  output logic       clockdr,
  output logic       shiftdr,
  output logic       updatedr,
  output logic       clockir,
  output logic       shiftir,
  output logic       updateir,
  output logic       select,
  output logic       bs_en,
  output logic       tlr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e state_q;

  logic shiftdr_q, shiftir_q, bs_en_q, select_q, tlr_q, en_dr, en_ir;

  // Ternary selects (not if/else) so an unknown TMS yields an unknown
  // next state instead of silently taking the TMS=0 branch.
  always_ff @(posedge TCLK or posedge TRST) begin
    if (TRST) begin
      state_q <= TLR;
    end else begin
      case (state_q)
        TLR:     state_q <= TMS ? TLR    : RTI;
        RTI:     state_q <= TMS ? SEL_DR : RTI;
        SEL_DR:  state_q <= TMS ? SEL_IR : CAP_DR;
        CAP_DR:  state_q <= TMS ? EX1_DR : SH_DR;
        SH_DR:   state_q <= TMS ? EX1_DR : SH_DR;
        EX1_DR:  state_q <= TMS ? UPD_DR : PAU_DR;
        PAU_DR:  state_q <= TMS ? EX2_DR : PAU_DR;
        EX2_DR:  state_q <= TMS ? UPD_DR : SH_DR;
        UPD_DR:  state_q <= TMS ? SEL_DR : RTI;
        SEL_IR:  state_q <= TMS ? TLR    : CAP_IR;
        CAP_IR:  state_q <= TMS ? EX1_IR : SH_IR;
        SH_IR:   state_q <= TMS ? EX1_IR : SH_IR;
        EX1_IR:  state_q <= TMS ? UPD_IR : PAU_IR;
        PAU_IR:  state_q <= TMS ? EX2_IR : PAU_IR;
        EX2_IR:  state_q <= TMS ? UPD_IR : SH_IR;
        UPD_IR:  state_q <= TMS ? SEL_DR : RTI;
        default: state_q <= TLR;
      endcase
    end
  end

  // Enables change only while TCLK is low, which keeps the gated clocks
  // glitch-free and the flags stable across the next rising edge.
  always_ff @(negedge TCLK or posedge TRST) begin
    if (TRST) begin
      shiftdr_q <= 1'b0;
      shiftir_q <= 1'b0;
      bs_en_q   <= 1'b0;
      select_q  <= 1'b0;
      tlr_q     <= 1'b1;
      en_dr     <= 1'b0;
      en_ir     <= 1'b0;
    end else begin
      shiftdr_q <= (state_q == SH_DR);
      shiftir_q <= (state_q == SH_IR);
      bs_en_q   <= (state_q == SH_DR) || (state_q == SH_IR);
      select_q  <= state_q inside {SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR};
      tlr_q     <= (state_q == TLR);
      en_dr     <= (state_q == CAP_DR) || (state_q == SH_DR);
      en_ir     <= (state_q == CAP_IR) || (state_q == SH_IR);
    end
  end

  generate
    if (GATE_CLOCKS) begin : g_gated
      assign clockdr = TCLK & en_dr;
      assign clockir = TCLK & en_ir;
    end else begin : g_level
      assign clockdr = en_dr;
      assign clockir = en_ir;
    end
  endgenerate

  assign updatedr = ~TCLK & (state_q == UPD_DR);
  assign updateir = ~TCLK & (state_q == UPD_IR);
  assign shiftdr  = shiftdr_q;
  assign shiftir  = shiftir_q;
  assign bs_en    = bs_en_q;
  assign select   = select_q;
  assign tlr      = tlr_q;
  assign state    = state_q;

endmodule
